// File: rtl/stretch_pkg.sv
// Shared types and default timing constants for the LED pulse stretcher.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stretch_pkg;

   // Stretcher FSM state encoding.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Default window lengths, in Clk cycles.
   localparam int DEF_HOLD_CYCLES = 3000000;
   localparam int DEF_GAP_CYCLES  = 500000;
   localparam int DEF_CNT_W       = 22;

   // The button debouncer's dead time matches the LED off gap, so both
   // blocks stay in step when the LED mirrors a debounced button.
   localparam int DEBOUNCE_DEAD_CYCLES = DEF_GAP_CYCLES;

   // The LED path is occupied whenever the FSM is in a window or a gap.
   function automatic logic is_busy(input state_t s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one flop of history, rise = din & ~din_q.
// Latency: combinational from din; history updates on every Clk edge.
// Backpressure: none.
//
// Ports:
//   Clk     - system clock, rising edge
//   nReset  - asynchronous active-low reset; history loads RST_VAL
//   din     - level input
//   rise    - high while din is 1 and was 0 at the previous edge
module rise_detect #(
   // A reset value of 1 means a level already high at reset release
   // is not reported as an edge.
   parameter logic RST_VAL = 1'b1
) (
   input  logic Clk,
   input  logic nReset,
   input  logic din,
   output logic rise
);

   logic din_q;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         din_q <= RST_VAL;
      end else begin
         din_q <= din;
      end
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event strobes into LED-on windows of HOLD_CYCLES,
// each followed by a forced LED-off gap of GAP_CYCLES.
// Latency: event sampled at edge k drives Led high from edge k; no backpressure,
//          overflow beyond one queued event is flagged on Overrun.
//
// Ports:
//   Clk      - system clock, rising edge
//   nReset   - asynchronous active-low reset
//   Enable   - synchronous enable; 0 forces idle and clears the queue
//   Trigger  - event input; its rising edge is the event
//   Led      - registered LED drive, active high
//   Busy     - registered; high during ON and GAP
//   Pending  - registered; one event queued for the next window
//   Overrun  - registered one-cycle pulse; an event was dropped
module led_pulse_stretcher
   import stretch_pkg::*;
#(
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter bit RETRIGGER   = 1'b1
) (
   input  logic Clk,
   input  logic nReset,
   input  logic Enable,
   input  logic Trigger,
   output logic Led,
   output logic Busy,
   output logic Pending,
   output logic Overrun
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             pend_d;
   logic             ovr_d;
   logic             rise;
   logic             evt;
   logic             hold_end;
   logic             gap_end;

   rise_detect #(
      .RST_VAL (1'b1)
   ) u_rise (
      .Clk    (Clk),
      .nReset (nReset),
      .din    (Trigger),
      .rise   (rise)
   );

   // The edge detector keeps tracking Trigger while disabled; only the
   // event itself is masked.
   assign evt      = rise & Enable;
   assign hold_end = (cnt_q == HOLD_LAST);
   assign gap_end  = (cnt_q == GAP_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      pend_d  = Pending;
      ovr_d   = 1'b0;

      if (!Enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (evt) begin
                  state_d = ON;
               end
            end

            ON: begin
               if (evt && RETRIGGER) begin
                  // Restart the hold window, even on its final cycle.
                  cnt_d = '0;
               end else begin
                  if (evt) begin
                     if (Pending) begin
                        ovr_d = 1'b1;
                     end else begin
                        pend_d = 1'b1;
                     end
                  end
                  if (hold_end) begin
                     state_d = GAP;
                     cnt_d   = '0;
                  end
               end
            end

            GAP: begin
               if (gap_end) begin
                  cnt_d = '0;
                  if (Pending || evt) begin
                     // One event opens the next window directly. If a queued
                     // event and a fresh one coincide, only one can be served.
                     state_d = ON;
                     pend_d  = 1'b0;
                     ovr_d   = Pending & evt;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (evt) begin
                  if (Pending) begin
                     ovr_d = 1'b1;
                  end else begin
                     pend_d = 1'b1;
                  end
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         endcase
      end
   end

   // Outputs are registered from the next-state decode so they line up
   // with the state they describe.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         Led     <= 1'b0;
         Busy    <= 1'b0;
         Pending <= 1'b0;
         Overrun <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         Led     <= (state_d == ON);
         Busy    <= is_busy(state_d);
         Pending <= pend_d;
         Overrun <= ovr_d;
      end
   end

endmodule
